// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, datapath widths, parity sense.
package uart_pkg;

    localparam int BAUD_W  = 19;
    localparam int SHIFT_W = 10;
    localparam int BCNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } rx_state_t;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_sense_t;

    // Samples taken after the start bit: data bits, optional parity, one stop.
    function automatic logic [BCNT_W-1:0] frame_bits(input logic eight, input logic pen);
        return 4'd8 + {3'b000, eight} + {3'b000, pen};
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous input; resets to the idle-high level.
module rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; q is safe to use in the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rx_engine.sv
// UART receive engine: synchronizes RX, deframes start/data/parity/stop,
// and holds the received byte with ready and error status for the reader.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | counters cleared, waiting for rxs low
//   START | timing to mid start bit; high there is a false start
//   DATA  | one sample every K clocks into the shift register, N samples
//   DONE  | one cycle: remap data, compute flags, update status
module rx_engine
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              RX,
    input  logic [BAUD_W-1:0] K,
    input  logic              EIGHT,
    input  logic              PEN,
    input  logic              OHEL,
    input  logic              READ,
    output logic [7:0]        UART_RDATA,
    output logic              RXRDY,
    output logic              PERR,
    output logic              FERR,
    output logic              OVF
);

    logic               rxs;
    rx_state_t          state;
    rx_state_t          state_nx;
    logic [BAUD_W-1:0]  tcnt;
    logic [BCNT_W-1:0]  bcnt;
    logic [SHIFT_W-1:0] sr;

    logic [BAUD_W-1:0]  half_k;
    logic [BAUD_W-1:0]  last_tick;
    logic [BCNT_W-1:0]  nbits;

    logic               tcnt_clr;
    logic               tcnt_inc;
    logic               bcnt_clr;
    logic               take_sample;
    logic               frame_done;

    logic [SHIFT_W-1:0] sr_al;
    logic [BCNT_W-1:0]  pidx;
    logic [7:0]         rx_data;
    logic               pbit;
    logic               stop_bit;
    logic               par_exp;
    logic               perr_nx;
    logic               ferr_nx;

    rx_sync u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (RX),
        .q     (rxs)
    );

    assign half_k    = K >> 1;
    assign last_tick = K - 19'd1;
    assign nbits     = frame_bits(EIGHT, PEN);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and counter/sampling controls.
    always_comb begin
        state_nx    = state;
        tcnt_clr    = 1'b0;
        tcnt_inc    = 1'b0;
        bcnt_clr    = 1'b0;
        take_sample = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                tcnt_clr = 1'b1;
                bcnt_clr = 1'b1;
                if (!rxs) begin
                    state_nx = START;
                end
            end
            START: begin
                if (tcnt == half_k) begin
                    tcnt_clr = 1'b1;
                    state_nx = rxs ? IDLE : DATA;
                end else begin
                    tcnt_inc = 1'b1;
                end
            end
            DATA: begin
                if (tcnt == last_tick) begin
                    tcnt_clr    = 1'b1;
                    take_sample = 1'b1;
                    if (bcnt == nbits - 4'd1) begin
                        state_nx = DONE;
                    end
                end else begin
                    tcnt_inc = 1'b1;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                tcnt_clr   = 1'b1;
                bcnt_clr   = 1'b1;
                state_nx   = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Bit-time counter, sample counter and LSB-first shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt <= '0;
            bcnt <= '0;
            sr   <= '0;
        end else begin
            if (tcnt_clr) begin
                tcnt <= '0;
            end else if (tcnt_inc) begin
                tcnt <= tcnt + 19'd1;
            end
            if (bcnt_clr) begin
                bcnt <= '0;
            end else if (take_sample) begin
                bcnt <= bcnt + 4'd1;
            end
            if (take_sample) begin
                sr <= {rxs, sr[SHIFT_W-1:1]};
            end
        end
    end

    // Short frames leave the first sample above bit 0; shift it down so data
    // starts at bit 0, parity follows the data and the stop sample is on top.
    always_comb begin
        sr_al    = sr >> (4'd10 - nbits);
        rx_data  = EIGHT ? sr_al[7:0] : {1'b0, sr_al[6:0]};
        pidx     = EIGHT ? 4'd8 : 4'd7;
        pbit     = sr_al[pidx];
        stop_bit = sr_al[nbits - 4'd1];
        par_exp  = (^rx_data) ^ (par_sense_t'(OHEL) == PAR_ODD);
        perr_nx  = PEN & (pbit ^ par_exp);
        ferr_nx  = ~stop_bit;
    end

    // Received byte and status; a completing frame wins over a coincident READ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            UART_RDATA <= 8'h00;
            RXRDY      <= 1'b0;
            PERR       <= 1'b0;
            FERR       <= 1'b0;
            OVF        <= 1'b0;
        end else if (frame_done) begin
            UART_RDATA <= rx_data;
            RXRDY      <= 1'b1;
            PERR       <= perr_nx;
            FERR       <= ferr_nx;
            OVF        <= RXRDY;
        end else if (READ) begin
            RXRDY <= 1'b0;
            PERR  <= 1'b0;
            FERR  <= 1'b0;
            OVF   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_engine.sv
// Directed bench for rx_engine: serial frames driven bit by bit, status checked after each.
module tb_rx_engine;
    import uart_pkg::*;

    logic        clk;
    logic        reset;
    logic        RX;
    logic [18:0] K;
    logic        EIGHT;
    logic        PEN;
    logic        OHEL;
    logic        READ;
    logic [7:0]  UART_RDATA;
    logic        RXRDY;
    logic        PERR;
    logic        FERR;
    logic        OVF;

    int n_chk;
    int n_bad;
    bit found;

    rx_engine dut (
        .clk        (clk),
        .reset      (reset),
        .RX         (RX),
        .K          (K),
        .EIGHT      (EIGHT),
        .PEN        (PEN),
        .OHEL       (OHEL),
        .READ       (READ),
        .UART_RDATA (UART_RDATA),
        .RXRDY      (RXRDY),
        .PERR       (PERR),
        .FERR       (FERR),
        .OVF        (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        RX = v;
        repeat (K) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int ndata, input bit pen,
                              input bit pbit, input bit stopb);
        bit_time(1'b0);
        for (int i = 0; i < ndata; i++) bit_time(d[i]);
        if (pen) bit_time(pbit);
        bit_time(stopb);
        RX = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_read();
        @(negedge clk);
        READ = 1'b1;
        @(negedge clk);
        READ = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, 32'(UART_RDATA), 32'h00);
        chk({tag, "_rxrdy"}, 32'(RXRDY), 32'd0);
        chk({tag, "_perr"}, 32'(PERR), 32'd0);
        chk({tag, "_ferr"}, 32'(FERR), 32'd0);
        chk({tag, "_ovf"}, 32'(OVF), 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        reset = 1'b0;
        RX    = 1'b1;
        K     = 19'd16;
        EIGHT = 1'b1;
        PEN   = 1'b0;
        OHEL  = 1'b0;
        READ  = 1'b0;
        idle(4);
        chk_all_zero("reset");
        reset = 1'b1;
        idle(4);

        // 8N1 0xA5, then read
        send_frame(8'hA5, 8, 0, 0, 1);
        idle(2);
        chk("a5_data", 32'(UART_RDATA), 32'hA5);
        chk("a5_rxrdy", 32'(RXRDY), 32'd1);
        chk("a5_perr", 32'(PERR), 32'd0);
        chk("a5_ferr", 32'(FERR), 32'd0);
        chk("a5_ovf", 32'(OVF), 32'd0);
        pulse_read();
        chk("a5_read_rxrdy", 32'(RXRDY), 32'd0);
        chk("a5_read_data", 32'(UART_RDATA), 32'hA5);

        // 7E1 0x41: two ones, even parity bit 0 is correct, 1 is wrong
        EIGHT = 1'b0;
        PEN   = 1'b1;
        OHEL  = 1'b0;
        send_frame(8'h41, 7, 1, 0, 1);
        idle(2);
        chk("7e1_ok_data", 32'(UART_RDATA), 32'h41);
        chk("7e1_ok_perr", 32'(PERR), 32'd0);
        pulse_read();
        send_frame(8'h41, 7, 1, 1, 1);
        idle(2);
        chk("7e1_bad_data", 32'(UART_RDATA), 32'h41);
        chk("7e1_bad_perr", 32'(PERR), 32'd1);
        chk("7e1_bad_rxrdy", 32'(RXRDY), 32'd1);
        pulse_read();
        chk("7e1_read_perr", 32'(PERR), 32'd0);

        // 8O1 0x3C (four ones -> odd parity bit 1), stop driven low
        EIGHT = 1'b1;
        PEN   = 1'b1;
        OHEL  = 1'b1;
        send_frame(8'h3C, 8, 1, 1, 0);
        idle(2);
        chk("ferr_data", 32'(UART_RDATA), 32'h3C);
        chk("ferr_rxrdy", 32'(RXRDY), 32'd1);
        chk("ferr_ferr", 32'(FERR), 32'd1);
        chk("ferr_perr", 32'(PERR), 32'd0);
        idle(48);
        chk("ferr_recover_idle", 32'(dut.state), 32'(IDLE));
        chk("ferr_hold_ferr", 32'(FERR), 32'd1);
        pulse_read();

        // 8N1 overrun: two frames back to back without a read
        PEN  = 1'b0;
        OHEL = 1'b0;
        send_frame(8'h11, 8, 0, 0, 1);
        send_frame(8'h22, 8, 0, 0, 1);
        idle(2);
        chk("ovf_data", 32'(UART_RDATA), 32'h22);
        chk("ovf_ovf", 32'(OVF), 32'd1);
        chk("ovf_rxrdy", 32'(RXRDY), 32'd1);
        pulse_read();
        chk("ovf_read_ovf", 32'(OVF), 32'd0);

        // K/4-clock low glitch is a false start
        RX = 1'b0;
        idle(4);
        RX = 1'b1;
        idle(48);
        chk("glitch_idle", 32'(dut.state), 32'(IDLE));
        chk("glitch_rxrdy", 32'(RXRDY), 32'd0);

        // READ on the DONE cycle: the new byte still gets flagged
        found = 1'b0;
        fork
            send_frame(8'h96, 8, 0, 0, 1);
            begin
                for (int i = 0; i < 400 && !found; i++) begin
                    @(negedge clk);
                    if (dut.state == DONE) begin
                        READ = 1'b1;
                        @(negedge clk);
                        READ  = 1'b0;
                        found = 1'b1;
                    end
                end
            end
        join
        idle(2);
        chk("coinc_done_seen", 32'(found), 32'd1);
        chk("coinc_rxrdy", 32'(RXRDY), 32'd1);
        chk("coinc_data", 32'(UART_RDATA), 32'h96);
        chk("coinc_ovf", 32'(OVF), 32'd0);

        // Reset in the middle of data bit 4, then a clean 0x5A
        RX = 1'b0;
        idle(16);
        for (int i = 0; i < 4; i++) begin
            RX = (8'h5A >> i) & 8'h01;
            idle(16);
        end
        RX = 1'b1;
        idle(8);
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        idle(3);
        reset = 1'b1;
        idle(32);
        send_frame(8'h5A, 8, 0, 0, 1);
        idle(2);
        chk("post_reset_data", 32'(UART_RDATA), 32'h5A);
        chk("post_reset_rxrdy", 32'(RXRDY), 32'd1);
        chk("post_reset_ferr", 32'(FERR), 32'd0);
        chk("post_reset_ovf", 32'(OVF), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
